rot_arbiter: RTL

- Shares one N-bit barrel rotator among NREQ requesters.
- Each requester offers an operand and a rotate amount on a valid/ready channel.
- A round-robin arbiter grants one request per cycle into a 2-stage pipeline: operand register, then rotate and result register.
- Sits between the requesting engines and the rotator datapath, and owns all sequencing and backpressure for that datapath.

---
 rtl/rot_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/rot_arbiter.sv
// rtl/rot_arbiter.sv - round-robin shared barrel rotator, 2-stage pipeline
// Grants one requester per cycle into an operand stage, then rotates into a result stage.
module rot_arbiter #(
  parameter int N      = 256,
  parameter int LOG2_N = 8,
  parameter int NREQ   = 4,
  parameter int ID_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [0:NREQ-1]        req_valid,
  output logic [0:NREQ-1]        req_ready,
  input  logic [0:NREQ*N-1]      req_bits,
  input  logic [0:NREQ*LOG2_N-1] req_k,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [0:N-1]           resp_bits,
  output logic [0:ID_W-1]        resp_id
);

  logic              r_s1_v;
  logic [0:N-1]      r_s1_bits;
  logic [0:LOG2_N-1] r_s1_k;
  logic [ID_W-1:0]   r_s1_id;
  logic              r_s2_v;
  logic [0:N-1]      r_s2_bits;
  logic [ID_W-1:0]   r_s2_id;
  logic [ID_W-1:0]   r_ptr;

  logic              w_adv2;
  logic              w_s2_free;
  logic              w_adv1;
  logic              w_s1_free;
  logic              w_found;
  logic [ID_W-1:0]   w_gnt;
  logic              w_acc;
  logic [0:N-1]      w_rot;
  logic [0:N-1]      w_tmp;

  assign w_adv2    = r_s2_v & resp_ready;
  assign w_s2_free = ~r_s2_v | w_adv2;
  assign w_adv1    = r_s1_v & w_s2_free;
  assign w_s1_free = ~r_s1_v | w_adv1;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int off = 0; off < NREQ; off++) begin
      if (!w_found && req_valid[(int'(r_ptr) + off) % NREQ]) begin
        w_found = 1'b1;
        w_gnt   = ID_W'((int'(r_ptr) + off) % NREQ);
      end
    end
  end

  // Reset gating keeps req_ready low while rst is held, even though s1 reads as free.
  assign w_acc = w_found & w_s1_free & ~rst;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = w_acc && (w_gnt == ID_W'(i));
    end
  end

  // Layer s moves content up by N>>(s+1) positions when k[s] is set (k[0] is the MSB).
  always_comb begin
    w_rot = r_s1_bits;
    w_tmp = '0;
    for (int s = 0; s < LOG2_N; s++) begin
      w_tmp = w_rot;
      if (r_s1_k[s]) begin
        for (int j = 0; j < N; j++) begin
          w_tmp[j] = w_rot[(j + N - (N >> (s + 1))) % N];
        end
      end
      w_rot = w_tmp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v    <= 1'b0;
      r_s1_bits <= '0;
      r_s1_k    <= '0;
      r_s1_id   <= '0;
      r_s2_v    <= 1'b0;
      r_s2_bits <= '0;
      r_s2_id   <= '0;
      r_ptr     <= '0;
    end else begin
      if (w_acc) begin
        r_s1_v    <= 1'b1;
        r_s1_bits <= req_bits[int'(w_gnt) * N +: N];
        r_s1_k    <= req_k[int'(w_gnt) * LOG2_N +: LOG2_N];
        r_s1_id   <= w_gnt;
        r_ptr     <= (w_gnt == ID_W'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
      end else if (w_adv1) begin
        r_s1_v <= 1'b0;
      end
      if (w_adv1) begin
        r_s2_v    <= 1'b1;
        r_s2_bits <= w_rot;
        r_s2_id   <= r_s1_id;
      end else if (w_adv2) begin
        r_s2_v <= 1'b0;
      end
    end
  end

  assign resp_valid = r_s2_v;
  assign resp_bits  = r_s2_bits;
  assign resp_id    = r_s2_id;

endmodule
